// File: rtl/sort_ctrl_if.sv
// sort_ctrl_if: upstream stream, array control/readout and downstream stream of the sort controller.
// master = controller side, slave = surrounding source/array/consumer side.
interface sort_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              arr_clr;
    logic              arr_en;
    logic [DATA_W-1:0] arr_new_data;
    logic [CNT_W-1:0]  arr_rd_idx;
    logic [DATA_W-1:0] arr_rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        input  in_data, in_valid, in_last, arr_rd_data, out_ready,
        output in_ready, arr_clr, arr_en, arr_new_data, arr_rd_idx,
               out_data, out_valid, out_last, busy, count, overflow
    );

    modport slave (
        output in_data, in_valid, in_last, arr_rd_data, out_ready,
        input  in_ready, arr_clr, arr_en, arr_new_data, arr_rd_idx,
               out_data, out_valid, out_last, busy, count, overflow
    );
endinterface

// File: rtl/sort_ctrl.sv
// sort_ctrl: clears the sorting-cell array, loads one batch, waits for the ripple to settle,
// then drains the cells in index order onto a valid/ready stream.
module sort_ctrl #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 4,
    parameter int SETTLE_CYC = 2
) (
    input logic        clk,
    input logic        rst,
    sort_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam int SW = $clog2(SETTLE_CYC + 1);

    logic [2:0]        r_state;
    logic              r_arr_en;
    logic [DATA_W-1:0] r_new_data;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic [SW-1:0]     r_set;
    logic              w_in_hs;
    logic              w_full;
    logic              w_last;

    assign w_in_hs = (r_state == S_LOAD) && bus.in_valid;
    assign w_full  = r_cnt == CNT_W'(DEPTH - 1);
    assign w_last  = (r_state == S_DRAIN) && (r_idx == r_cnt - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_arr_en   <= 1'b0;
            r_new_data <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_set      <= '0;
        end else begin
            r_arr_en <= w_in_hs;
            case (r_state)
                S_IDLE: if (bus.in_valid) r_state <= S_CLEAR;
                S_CLEAR: begin
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_LOAD;
                end
                S_LOAD: if (w_in_hs) begin
                    r_new_data <= bus.in_data;
                    r_cnt      <= r_cnt + 1'b1;
                    if (bus.in_last || w_full) begin
                        r_state <= S_SETTLE;
                        r_set   <= '0;
                    end
                    if (w_full && !bus.in_last) r_ovf <= 1'b1;
                end
                // settle window starts on the cycle of the final insert pulse
                S_SETTLE: if (r_set == SW'(SETTLE_CYC - 1)) begin
                    r_state <= S_DRAIN;
                    r_idx   <= '0;
                end else begin
                    r_set <= r_set + 1'b1;
                end
                S_DRAIN: if (bus.out_ready) begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = r_state == S_LOAD;
    assign bus.arr_clr      = r_state == S_CLEAR;
    assign bus.arr_en       = r_arr_en;
    assign bus.arr_new_data = r_new_data;
    assign bus.arr_rd_idx   = r_idx;
    assign bus.out_data     = bus.arr_rd_data;
    assign bus.out_valid    = r_state == S_DRAIN;
    assign bus.out_last     = w_last;
    assign bus.busy         = r_state != S_IDLE;
    assign bus.count        = r_cnt;
    assign bus.overflow     = r_ovf;
endmodule
